neuron_lif_array: RTL and testbench
===================================

// Module: neuron_lif_array
// PURPOSE
//   Layer of NEURONS leaky integrate-and-fire neurons sharing one time-multiplexed LIF datapath.
//   Per-neuron membrane, refractory counter and binary weight row are held in local register arrays.
//   Accepts one input spike vector per valid/ready handshake and sweeps the neurons one per cycle.
//   Emits a NEURONS-wide spike vector. Successor of the single-neuron LIF: adds channels, refractory period and weight storage.
// PARAMETERS
//   SYNAPSES        16                       input spikes per vector (power of 2, >=4)
//   NEURONS         4                        neurons in the layer (>=2)
//   MEMBRANE_BITS   $clog2(SYNAPSES)+2       signed membrane width
//   THRESHOLD_BITS  MEMBRANE_BITS-1          unsigned threshold width
//   REFRACT_BITS    2                        refractory counter width
// PORTS
//   clk          in   1                 single clock, rising edge
//   reset_n      in   1                 reset, synchronous, active-low
//   in_valid     in   1                 input vector offered
//   in_ready     out  1                 block can accept a vector
//   inputs       in   SYNAPSES          input spike vector
//   shift        in   3                 decay shift; sampled on accept
//   threshold    in   THRESHOLD_BITS    firing threshold; sampled on accept
//   refractory   in   REFRACT_BITS      post-spike dead steps; sampled on accept
//   w_we         in   1                 weight-row write enable
//   w_addr       in   $clog2(NEURONS)   weight row to write
//   w_data       in   SYNAPSES          weight row; bit 1 = +1, bit 0 = -1
//   out_valid    out  1                 one-cycle pulse: out_spikes updated
//   out_spikes   out  NEURONS           spike bit per neuron
//   mem_sel      in   $clog2(NEURONS)   membrane readout select
//   mem_out      out  MEMBRANE_BITS     membrane[mem_sel], combinational
// BEHAVIOUR
// - Clocking: one clock clk. Reset reset_n is synchronous and active-low.
// - Reset: FSM=IDLE; in_ready=1; out_valid=0; out_spikes=0.
//   All membranes, refractory counters and weight rows are cleared to 0, so mem_out=0.
//   Reset asserted mid-sweep aborts the sweep. No out_valid pulse is produced for the aborted vector.
// - FSM states and transitions:
//   - IDLE -> PROC on in_valid&&in_ready. On accept, latch inputs, shift, threshold and refractory, and set k=0.
//   - PROC: neuron k is updated this cycle. If k==NEURONS-1 -> DONE, else k++.
//   - DONE: out_valid=1 for exactly this cycle, then -> IDLE.
// - Handshake:
//   - in_ready=1 only in IDLE. in_valid in PROC/DONE is ignored.
//   - Accept at cycle T gives out_valid at T+NEURONS+1. Next accept is possible at T+NEURONS+2.
// - Neuron update (neuron k, in PROC):
//   - psp = sum over i of inputs[i] ? (w[k][i] ? +1 : -1) : 0. Range -SYNAPSES..+SYNAPSES.
//   - decay: shift==0 gives u. Otherwise u - (u >>> shift), an arithmetic shift.
//   - acc = clamp(decay + psp) to [-2^(MEMBRANE_BITS-1), 2^(MEMBRANE_BITS-1)-1]. No wrap.
//   - If refr[k]!=0: membrane[k]<=0, refr[k]--, spike bit k=0. psp is ignored.
//   - Else, if acc >= $signed({0,threshold}): spike bit k=1, membrane[k]<=acc-threshold, refr[k]<=refractory.
//   - Else: spike bit k=0, membrane[k]<=acc.
//   - The bit-k write into out_spikes is internal. out_spikes is only visible as the new vector at DONE.
//     It is held stable from DONE until the next DONE.
// - Weights:
//   - w_we writes w_data into row w_addr at the clock edge, in any state.
//   - A write to the row being processed in the same cycle does not affect that cycle; the old row is used.
//   - A write takes effect for later neurons in the same sweep.
// STRUCTURE
// - Shared package lif_pkg holds: the FSM state enum (IDLE/PROC/DONE), the clamp min/max constant functions of width,
//   and the weight encoding constants (W_POS=1, W_NEG=0).
// - Sub-module lif_neuron_step: combinational psp, decay, clamp, threshold compare and subtract-reset.
//   Inputs: inputs, weight row, u, shift, threshold, refr. Outputs: u_next, spike, refr_next.
// - The top level holds the FSM, the neuron index counter, the register arrays and the output registers.
// TESTING (SYNAPSES=16, NEURONS=4, MEMBRANE_BITS=6, range -32..31)
// 1. Reset: hold reset_n=0 for 2 cycles -> in_ready=1, out_valid=0, out_spikes=0, mem_out=0 for every mem_sel.
// 2. Basic update: row0=FFFF, rows1-3=0000, inputs=FFFF, shift=0, thr=10, refr=0.
//    -> out_valid at T+5, out_spikes=4'b0001, membrane0=6, membrane1..3=-16.
// 3. Clamp: row0=0000, inputs=FFFF, shift=0, thr=31, three vectors -> membrane0 = -16, -32, -32. No wrap.
// 4. Decay:
//    - membrane0=8, inputs=0, shift=1 -> successive values 8, 4, 2, 1, 1.
//    - membrane0=-1 with shift=1 -> 0.
// 5. Refractory: row0=FFFF, inputs=FFFF, thr=10, refr=2, four vectors.
//    -> spike bit0 = 1, 0, 0, 1. membrane0 = 6, 0, 0, 6.
// 6. Handshake and abort:
//    - in_valid held high through PROC is not accepted.
//    - w_we to row k during PROC cycle k uses the old row.
//    - reset_n=0 in PROC cycle 2 -> in_ready=1 next cycle, no out_valid, all membranes 0.

Source files
------------

// File: rtl/lif_pkg.sv
`default_nettype none
// ============================================================================
// Module : lif_pkg
// Brief  : Shared FSM states, clamp bounds and weight encoding for the LIF layer.
// Rev    : 1.0 - initial release
// ============================================================================
package lif_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROC = 2'd1,
    DONE = 2'd2
  } lif_state_t;

  localparam logic W_POS = 1'b1;
  localparam logic W_NEG = 1'b0;

  function automatic int clamp_max(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  function automatic int clamp_min(input int width);
    return -(1 << (width - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/lif_neuron_step.sv
`default_nettype none
// ============================================================================
// Module : lif_neuron_step
// Brief  : One combinational LIF update: psp, leak, saturate, fire and reset.
// Rev    : 1.0 - initial release
// ============================================================================
module lif_neuron_step
  import lif_pkg::*;
#(
  parameter int SYNAPSES       = 16,
  parameter int MEMBRANE_BITS  = $clog2(SYNAPSES) + 2,
  parameter int THRESHOLD_BITS = MEMBRANE_BITS - 1,
  parameter int REFRACT_BITS   = 2
) (
  input  logic [SYNAPSES-1:0]             inputs,
  input  logic [SYNAPSES-1:0]             weights,
  input  logic signed [MEMBRANE_BITS-1:0] u,
  input  logic [2:0]                      shift,
  input  logic [THRESHOLD_BITS-1:0]       threshold,
  input  logic [REFRACT_BITS-1:0]         refr,
  input  logic [REFRACT_BITS-1:0]         refractory,
  output logic signed [MEMBRANE_BITS-1:0] u_next,
  output logic                            spike,
  output logic [REFRACT_BITS-1:0]         refr_next
);

  // Wide enough that decay + psp never overflows before saturation.
  localparam int ACC_BITS = MEMBRANE_BITS + $clog2(SYNAPSES) + 2;
  localparam logic signed [ACC_BITS-1:0] c_acc_max = ACC_BITS'(clamp_max(MEMBRANE_BITS));
  localparam logic signed [ACC_BITS-1:0] c_acc_min = ACC_BITS'(clamp_min(MEMBRANE_BITS));

  logic signed [ACC_BITS-1:0]      w_psp;
  logic signed [ACC_BITS-1:0]      w_decay;
  logic signed [ACC_BITS-1:0]      w_sum;
  logic signed [MEMBRANE_BITS-1:0] w_shifted;
  logic signed [MEMBRANE_BITS-1:0] w_leaked;
  logic signed [MEMBRANE_BITS-1:0] w_acc;
  logic signed [MEMBRANE_BITS-1:0] w_thr;

  always_comb begin
    w_psp = '0;
    for (int i = 0; i < SYNAPSES; i++) begin
      if (inputs[i]) begin
        case (weights[i])
          W_POS: w_psp = w_psp + ACC_BITS'(1);
          W_NEG: w_psp = w_psp - ACC_BITS'(1);
        endcase
      end
    end
  end

  assign w_shifted = u >>> shift;
  assign w_leaked  = u - w_shifted;
  assign w_decay   = (shift == 3'd0) ? ACC_BITS'(u) : ACC_BITS'(w_leaked);
  assign w_sum     = w_decay + w_psp;
  assign w_thr     = $signed(MEMBRANE_BITS'({1'b0, threshold}));

  always_comb begin
    if (w_sum > c_acc_max) begin
      w_acc = MEMBRANE_BITS'(c_acc_max);
    end else if (w_sum < c_acc_min) begin
      w_acc = MEMBRANE_BITS'(c_acc_min);
    end else begin
      w_acc = w_sum[MEMBRANE_BITS-1:0];
    end
  end

  // A refractory neuron is held at rest and ignores its input this step.
  always_comb begin
    u_next    = w_acc;
    spike     = 1'b0;
    refr_next = refr;
    if (refr != '0) begin
      u_next    = '0;
      refr_next = refr - REFRACT_BITS'(1);
    end else if (w_acc >= w_thr) begin
      spike     = 1'b1;
      u_next    = w_acc - w_thr;
      refr_next = refractory;
    end
  end

endmodule
`default_nettype wire

// File: rtl/neuron_lif_array.sv
`default_nettype none
// ============================================================================
// Module : neuron_lif_array
// Brief  : LIF neuron layer sweeping one neuron per cycle through a shared step.
// Rev    : 1.0 - initial release
// ============================================================================
module neuron_lif_array
  import lif_pkg::*;
#(
  parameter int SYNAPSES       = 16,
  parameter int NEURONS        = 4,
  parameter int MEMBRANE_BITS  = $clog2(SYNAPSES) + 2,
  parameter int THRESHOLD_BITS = MEMBRANE_BITS - 1,
  parameter int REFRACT_BITS   = 2
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [SYNAPSES-1:0]             inputs,
  input  logic [2:0]                      shift,
  input  logic [THRESHOLD_BITS-1:0]       threshold,
  input  logic [REFRACT_BITS-1:0]         refractory,
  input  logic                            w_we,
  input  logic [$clog2(NEURONS)-1:0]      w_addr,
  input  logic [SYNAPSES-1:0]             w_data,
  output logic                            out_valid,
  output logic [NEURONS-1:0]              out_spikes,
  input  logic [$clog2(NEURONS)-1:0]      mem_sel,
  output logic signed [MEMBRANE_BITS-1:0] mem_out
);

  localparam int IDX_BITS = $clog2(NEURONS);
  localparam logic [IDX_BITS-1:0] c_last_idx = IDX_BITS'(NEURONS - 1);

  lif_state_t r_state;
  lif_state_t w_state_next;

  logic [IDX_BITS-1:0]             r_idx;
  logic [SYNAPSES-1:0]             r_inputs;
  logic [2:0]                      r_shift;
  logic [THRESHOLD_BITS-1:0]       r_threshold;
  logic [REFRACT_BITS-1:0]         r_refractory;
  logic signed [MEMBRANE_BITS-1:0] r_membrane [NEURONS];
  logic [REFRACT_BITS-1:0]         r_refr     [NEURONS];
  logic [SYNAPSES-1:0]             r_weights  [NEURONS];
  logic [NEURONS-1:0]              r_work;
  logic [NEURONS-1:0]              r_spikes;

  logic                            w_accept;
  logic signed [MEMBRANE_BITS-1:0] w_u_next;
  logic                            w_spike;
  logic [REFRACT_BITS-1:0]         w_refr_next;
  logic [NEURONS-1:0]              w_spikes_final;

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == DONE);
  assign out_spikes = r_spikes;
  assign mem_out    = r_membrane[mem_sel];
  assign w_accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_next = PROC;
      PROC:    if (r_idx == c_last_idx) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  lif_neuron_step #(
    .SYNAPSES       (SYNAPSES),
    .MEMBRANE_BITS  (MEMBRANE_BITS),
    .THRESHOLD_BITS (THRESHOLD_BITS),
    .REFRACT_BITS   (REFRACT_BITS)
  ) u_step (
    .inputs     (r_inputs),
    .weights    (r_weights[r_idx]),
    .u          (r_membrane[r_idx]),
    .shift      (r_shift),
    .threshold  (r_threshold),
    .refr       (r_refr[r_idx]),
    .refractory (r_refractory),
    .u_next     (w_u_next),
    .spike      (w_spike),
    .refr_next  (w_refr_next)
  );

  // The last neuron's bit is merged on the fly so the full vector lands at DONE.
  always_comb begin
    w_spikes_final        = r_work;
    w_spikes_final[r_idx] = w_spike;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_idx        <= '0;
      r_inputs     <= '0;
      r_shift      <= '0;
      r_threshold  <= '0;
      r_refractory <= '0;
      r_work       <= '0;
      r_spikes     <= '0;
      for (int k = 0; k < NEURONS; k++) begin
        r_membrane[k] <= '0;
        r_refr[k]     <= '0;
        r_weights[k]  <= '0;
      end
    end else begin
      if (w_accept) begin
        r_inputs     <= inputs;
        r_shift      <= shift;
        r_threshold  <= threshold;
        r_refractory <= refractory;
        r_idx        <= '0;
      end
      if (r_state == PROC) begin
        r_membrane[r_idx] <= w_u_next;
        r_refr[r_idx]     <= w_refr_next;
        r_work[r_idx]     <= w_spike;
        if (r_idx == c_last_idx) begin
          r_spikes <= w_spikes_final;
        end else begin
          r_idx <= r_idx + IDX_BITS'(1);
        end
      end
      if (w_we) begin
        r_weights[w_addr] <= w_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_neuron_lif_array.sv
`default_nettype none
// ============================================================================
// Module : tb_neuron_lif_array
// Brief  : Self-checking bench: per-cycle reference model plus directed vectors.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_neuron_lif_array;

  localparam int S  = 16;
  localparam int N  = 4;
  localparam int MB = 6;

  logic                 clk;
  logic                 reset_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [S-1:0]         inputs;
  logic [2:0]           shift;
  logic [MB-2:0]        threshold;
  logic [1:0]           refractory;
  logic                 w_we;
  logic [1:0]           w_addr;
  logic [S-1:0]         w_data;
  logic                 out_valid;
  logic [N-1:0]         out_spikes;
  logic [1:0]           mem_sel;
  logic signed [MB-1:0] mem_out;

  int compared   = 0;
  int mismatched = 0;

  neuron_lif_array #(
    .SYNAPSES (S),
    .NEURONS  (N)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .inputs     (inputs),
    .shift      (shift),
    .threshold  (threshold),
    .refractory (refractory),
    .w_we       (w_we),
    .w_addr     (w_addr),
    .w_data     (w_data),
    .out_valid  (out_valid),
    .out_spikes (out_spikes),
    .mem_sel    (mem_sel),
    .mem_out    (mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int           m_mem  [N];
  int           m_refr [N];
  logic [S-1:0] m_w    [N];
  logic [S-1:0] m_in;
  int           m_sh, m_th, m_rf;
  int           m_phase;      // 0 idle, 1..N neuron phase-1 in flight, N+1 output slot
  logic [N-1:0] m_work, m_out;
  bit           m_init = 0;

  task automatic model_neuron(input int k);
    int psp, dec, acc, d, q;
    psp = 0;
    for (int i = 0; i < S; i++)
      if (m_in[i]) psp += m_w[k][i] ? 1 : -1;
    if (m_sh == 0) dec = m_mem[k];
    else begin
      d   = 1 << m_sh;
      q   = (m_mem[k] >= 0) ? m_mem[k] / d : -((-m_mem[k] + d - 1) / d);
      dec = m_mem[k] - q;
    end
    acc = dec + psp;
    if (acc > 31)  acc = 31;
    if (acc < -32) acc = -32;
    if (m_refr[k] != 0) begin
      m_mem[k]  = 0;
      m_refr[k] = m_refr[k] - 1;
      m_work[k] = 1'b0;
    end else if (acc >= m_th) begin
      m_mem[k]  = acc - m_th;
      m_refr[k] = m_rf;
      m_work[k] = 1'b1;
    end else begin
      m_mem[k]  = acc;
      m_work[k] = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < N; k++) begin
        m_mem[k] = 0; m_refr[k] = 0; m_w[k] = '0;
      end
      m_phase = 0; m_out = '0; m_work = '0; m_init = 1;
    end else if (m_init) begin
      if (m_phase >= 1 && m_phase <= N) model_neuron(m_phase - 1);
      if (w_we) m_w[w_addr] = w_data;
      if (m_phase == 0) begin
        if (in_valid) begin
          m_in = inputs; m_sh = int'(shift); m_th = int'(threshold); m_rf = int'(refractory);
          m_phase = 1;
        end
      end else if (m_phase <= N) begin
        m_phase++;
        if (m_phase == N + 1) m_out = m_work;
      end else begin
        m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("in_ready",   int'(in_ready),   int'(m_phase == 0));
      check("out_valid",  int'(out_valid),  int'(m_phase == N + 1));
      check("out_spikes", int'(out_spikes), int'(m_out));
      check("mem_out",    int'(mem_out),    m_mem[mem_sel]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick(); reset_n = 1'b0;
    tick(); tick(); reset_n = 1'b1;
  endtask

  task automatic write_row(input logic [1:0] a, input logic [S-1:0] d);
    tick(); w_we = 1'b1; w_addr = a; w_data = d;
    tick(); w_we = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    if (!in_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic offer(input logic [S-1:0] v, input logic [2:0] sh, input logic [4:0] th,
                       input logic [1:0] rf);
    tick(); wait_ready();
    in_valid = 1'b1; inputs = v; shift = sh; threshold = th; refractory = rf;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    if (!out_valid) check("done_timeout", 0, 1);
  endtask

  task automatic send(input logic [S-1:0] v, input logic [2:0] sh, input logic [4:0] th,
                      input logic [1:0] rf, output logic [N-1:0] sp);
    int lat;
    offer(v, sh, th, rf);
    tick(); in_valid = 1'b0;
    wait_done(lat);
    check("latency", lat, N + 1);
    sp = out_spikes;
  endtask

  task automatic check_mem(input int k, input int exp);
    tick(); mem_sel = 2'(k); #1;
    check($sformatf("mem%0d", k), int'(mem_out), exp);
  endtask

  logic [N-1:0] sp;
  int           pulses;
  int           exp3 [3] = '{-16, -32, -32};
  int           exp4 [4] = '{4, 2, 1, 1};
  int           exp5m [4] = '{6, 0, 0, 6};
  int           exp5s [4] = '{1, 0, 0, 1};

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; inputs = '0; shift = '0; threshold = '0;
    refractory = '0; w_we = 1'b0; w_addr = '0; w_data = '0; mem_sel = '0;
    repeat (2) @(posedge clk);
    tick(); reset_n = 1'b1;

    // reset state
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_spikes", int'(out_spikes), 0);
    for (int k = 0; k < N; k++) check_mem(k, 0);

    // basic update
    write_row(2'd0, 16'hFFFF);
    send(16'hFFFF, 3'd0, 5'd10, 2'd0, sp);
    check("basic_spikes", int'(sp), 4'b0001);
    check_mem(0, 6);
    for (int k = 1; k < N; k++) check_mem(k, -16);

    // saturation at the negative rail
    do_reset();
    for (int j = 0; j < 3; j++) begin
      send(16'hFFFF, 3'd0, 5'd31, 2'd0, sp);
      check_mem(0, exp3[j]);
    end

    // leak toward zero
    do_reset();
    write_row(2'd0, 16'hFFFF);
    send(16'h00FF, 3'd0, 5'd31, 2'd0, sp);
    check_mem(0, 8);
    for (int j = 0; j < 4; j++) begin
      send(16'h0000, 3'd1, 5'd31, 2'd0, sp);
      check_mem(0, exp4[j]);
    end
    do_reset();
    send(16'h0001, 3'd0, 5'd31, 2'd0, sp);
    check_mem(0, -1);
    send(16'h0000, 3'd1, 5'd31, 2'd0, sp);
    check_mem(0, 0);

    // refractory period
    do_reset();
    write_row(2'd0, 16'hFFFF);
    for (int j = 0; j < 4; j++) begin
      send(16'hFFFF, 3'd0, 5'd10, 2'd2, sp);
      check("refr_spike0", int'(sp[0]), exp5s[j]);
      check_mem(0, exp5m[j]);
    end

    // in_valid held through the sweep is not re-accepted mid-sweep
    do_reset();
    write_row(2'd0, 16'hFFFF);
    offer(16'hFFFF, 3'd0, 5'd10, 2'd0);
    pulses = 0;
    for (int j = 0; j < N + 1; j++) begin
      tick();
      if (out_valid) pulses++;
    end
    in_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      if (out_valid) pulses++;
    end
    check("hold_pulses", pulses, 1);
    check_mem(0, 6);

    // weight write to the row in flight uses the old row
    do_reset();
    write_row(2'd1, 16'hFFFF);
    offer(16'hFFFF, 3'd0, 5'd31, 2'd0);
    tick(); in_valid = 1'b0;
    tick(); w_we = 1'b1; w_addr = 2'd1; w_data = 16'h0000;
    tick(); w_we = 1'b0;
    wait_done(pulses);
    check_mem(1, 16);
    send(16'hFFFF, 3'd0, 5'd31, 2'd0, sp);
    check_mem(1, 0);

    // reset mid-sweep aborts
    do_reset();
    write_row(2'd0, 16'hFFFF);
    send(16'hFFFF, 3'd0, 5'd31, 2'd0, sp);
    check_mem(0, 16);
    offer(16'hFFFF, 3'd0, 5'd31, 2'd0);
    tick(); in_valid = 1'b0;
    tick();
    tick(); reset_n = 1'b0;
    tick(); reset_n = 1'b1;
    check("abort_in_ready", int'(in_ready), 1);
    pulses = 0;
    for (int j = 0; j < 8; j++) begin
      tick();
      if (out_valid) pulses++;
    end
    check("abort_pulses", pulses, 0);
    for (int k = 0; k < N; k++) check_mem(k, 0);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
